// File: rtl/radix4_pkg.sv
// radix4_pkg: shared FSM states, Booth digit encoding and step-count helper
package radix4_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} booth_digit_t;
    function automatic int steps(input int width);
        return width / 2 + 1;
    endfunction
endpackage

// File: rtl/radix4_booth_enc.sv
// radix4_booth_enc: recodes a 3-bit multiplier window into a radix-4 Booth digit
module radix4_booth_enc
    import radix4_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);
    // 011 and 100 are the only double-weight windows; the rest split on the sign bit
    always_comb digit = (window == 3'b011) ? BD_P2 :
                        (window == 3'b100) ? BD_M2 :
                        (window == 3'b000 || window == 3'b111) ? BD_ZERO :
                        window[2] ? BD_M1 : BD_P1;
endmodule

// File: rtl/radix4_seq_mult.sv
// radix4_seq_mult: sequential radix-4 Booth multiplier retiring one digit per clock
module radix4_seq_mult
    import radix4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   inputA,
    input  logic [WIDTH-1:0]   inputB,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done
);
    localparam int N  = steps(WIDTH);
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam int AW = 2 * WIDTH + 4;

    state_t           state, state_nx;
    booth_digit_t     digit;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+2:0] mplier;
    logic [AW-1:0]    acc;
    logic [WIDTH+2:0] ae, pp;
    logic [WIDTH+3:0] hi;
    logic             last;

    assign last = cnt == CW'(N);
    assign ae   = {mcand[WIDTH+1], mcand};

    radix4_booth_enc u_enc (
        .window(mplier[2:0]),
        .digit (digit)
    );

    // partial product: digit times the extended multiplicand
    always_comb pp = digit == BD_P1 ? ae :
                     digit == BD_P2 ? ae << 1 :
                     digit == BD_M1 ? -ae :
                     digit == BD_M2 ? -(ae << 1) : '0;

    // upper half gets two guard bits so the sum cannot wrap before the shift
    assign hi = {{2{acc[AW-1]}}, acc[AW-1:WIDTH+2]} + {pp[WIDTH+2], pp};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and handshake outputs; RUN holds one extra cycle after the last step
    always_comb begin
        state_nx = state;
        busy     = state == RUN;
        done     = state == DONE;
        if (state == IDLE && start) state_nx = RUN;
        if (state == RUN && last)   state_nx = DONE;
        if (state == DONE)          state_nx = IDLE;
    end

    // operand capture, Booth steps, and product write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            out    <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= {{2{signed_mode & inputA[WIDTH-1]}}, inputA};
            mplier <= {{2{signed_mode & inputB[WIDTH-1]}}, inputB, 1'b0};
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN && !last) begin
            acc    <= {hi, acc[WIDTH+1:2]};
            mplier <= {{2{mplier[WIDTH+2]}}, mplier[WIDTH+2:2]};
            cnt    <= cnt + CW'(1);
        end else if (state == RUN) begin
            out    <= acc[2*WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_radix4_seq_mult.sv
// tb_radix4_seq_mult: scoreboard bench for the Booth multiplier at several widths
module tb_radix4_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic         start32 = 1'b0, sm32 = 1'b0;
    logic [31:0]  a32 = '0, b32 = '0;
    logic [63:0]  out32;
    logic         busy32, done32;
    logic [63:0]  q32[$];

    logic         start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic [15:0]  out8;
    logic         busy8, done8;
    logic [15:0]  q8[$];

    logic         start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]   a4 = '0, b4 = '0;
    logic [7:0]   out4;
    logic         busy4, done4;
    logic [7:0]   q4[$];

    logic         start64 = 1'b0, sm64 = 1'b0;
    logic [63:0]  a64 = '0, b64 = '0;
    logic [127:0] out64;
    logic         busy64, done64;
    logic [127:0] q64[$];

    radix4_seq_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .inputA(a32), .inputB(b32), .out(out32), .busy(busy32), .done(done32)
    );
    radix4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .inputA(a8), .inputB(b8), .out(out8), .busy(busy8), .done(done8)
    );
    radix4_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .inputA(a4), .inputB(b4), .out(out4), .busy(busy4), .done(done4)
    );
    radix4_seq_mult #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .signed_mode(sm64),
        .inputA(a64), .inputB(b64), .out(out64), .busy(busy64), .done(done64)
    );

    // scoreboard checkers: every done pulse pops one expected product
    always @(negedge clk) begin : mon32
        logic [63:0] e;
        if (done32 === 1'b1) begin
            tests++;
            if (q32.size() == 0) begin
                fails++;
                $display("FAIL w32_spurious_done out=%h, expected no done", out32);
            end else begin
                e = q32.pop_front();
                if (out32 !== e) begin
                    fails++;
                    $display("FAIL w32_product out=%h, expected %h", out32, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [15:0] e;
        if (done8 === 1'b1) begin
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL w8_spurious_done out=%h, expected no done", out8);
            end else begin
                e = q8.pop_front();
                if (out8 !== e) begin
                    fails++;
                    $display("FAIL w8_product a=%h b=%h s=%b out=%h, expected %h", a8, b8, sm8, out8, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon4
        logic [7:0] e;
        if (done4 === 1'b1) begin
            tests++;
            if (q4.size() == 0) begin
                fails++;
                $display("FAIL w4_spurious_done out=%h, expected no done", out4);
            end else begin
                e = q4.pop_front();
                if (out4 !== e) begin
                    fails++;
                    $display("FAIL w4_product a=%h b=%h s=%b out=%h, expected %h", a4, b4, sm4, out4, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon64
        logic [127:0] e;
        if (done64 === 1'b1) begin
            tests++;
            if (q64.size() == 0) begin
                fails++;
                $display("FAIL w64_spurious_done out=%h, expected no done", out64);
            end else begin
                e = q64.pop_front();
                if (out64 !== e) begin
                    fails++;
                    $display("FAIL w64_product a=%h b=%h s=%b out=%h, expected %h", a64, b64, sm64, out64, e);
                end
            end
        end
    end

    task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
        int lat;
        logic [63:0] prev;
        bit moved, idle;
        @(negedge clk);
        start32 = 1'b1; sm32 = s; a32 = x; b32 = y;
        q32.push_back(exp);
        @(posedge clk); #1;
        start32 = 1'b0; sm32 = ~s; a32 = $urandom; b32 = $urandom;
        prev = out32; moved = 0; idle = 0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (done32 === 1'b1) break;
            if (out32 !== prev) moved = 1;
            if (busy32 !== 1'b1) idle = 1;
        end
        tests++;
        if (lat != 18) begin fails++; $display("FAIL w32_latency got=%0d, expected 18", lat); end
        tests++;
        if (moved) begin fails++; $display("FAIL w32_out_stable out changed to %h during run, expected %h", out32, prev); end
        tests++;
        if (idle) begin fails++; $display("FAIL w32_busy_during_run busy dropped, expected 1"); end
        tests++;
        if (busy32 !== 1'b0) begin fails++; $display("FAIL w32_busy_in_done busy=%b, expected 0", busy32); end
        @(negedge clk);
        tests++;
        if (done32 !== 1'b0 || busy32 !== 1'b0) begin
            fails++; $display("FAIL w32_done_pulse done=%b busy=%b, expected 0 0", done32, busy32);
        end
    endtask

    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int lat;
        @(negedge clk);
        start8 = 1'b1; sm8 = s; a8 = x; b8 = y;
        q8.push_back(s ? 16'($signed(x)) * 16'($signed(y)) : 16'(x) * 16'(y));
        @(posedge clk); #1 start8 = 1'b0;
        for (lat = 0; lat < 20; lat++) begin
            @(negedge clk);
            if (done8 === 1'b1) break;
        end
        tests++;
        if (lat != 6) begin fails++; $display("FAIL w8_latency got=%0d, expected 6", lat); end
    endtask

    task automatic op4(input logic s, input logic [3:0] x, input logic [3:0] y);
        int lat;
        @(negedge clk);
        start4 = 1'b1; sm4 = s; a4 = x; b4 = y;
        q4.push_back(s ? 8'($signed(x)) * 8'($signed(y)) : 8'(x) * 8'(y));
        @(posedge clk); #1 start4 = 1'b0;
        for (lat = 0; lat < 20; lat++) begin
            @(negedge clk);
            if (done4 === 1'b1) break;
        end
        tests++;
        if (lat != 4) begin fails++; $display("FAIL w4_latency got=%0d, expected 4", lat); end
    endtask

    task automatic op64(input logic s, input logic [63:0] x, input logic [63:0] y);
        int lat;
        @(negedge clk);
        start64 = 1'b1; sm64 = s; a64 = x; b64 = y;
        q64.push_back(s ? 128'($signed(x)) * 128'($signed(y)) : 128'(x) * 128'(y));
        @(posedge clk); #1 start64 = 1'b0;
        for (lat = 0; lat < 60; lat++) begin
            @(negedge clk);
            if (done64 === 1'b1) break;
        end
        tests++;
        if (lat != 34) begin fails++; $display("FAIL w64_latency got=%0d, expected 34", lat); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out32 !== 64'd0) begin fails++; $display("FAIL reset_out out=%h, expected 0", out32); end
        tests++;
        if (busy32 !== 1'b0) begin fails++; $display("FAIL reset_busy busy=%b, expected 0", busy32); end
        tests++;
        if (done32 !== 1'b0) begin fails++; $display("FAIL reset_done done=%b, expected 0", done32); end
        tests++;
        if (out8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++; $display("FAIL reset_w8 out=%h busy=%b done=%b, expected 0 0 0", out8, busy8, done8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed;
        op32(1'b1, 32'd553524, 32'd840, 64'd464960160);
        op32(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 64'd4);
        op32(1'b1, 32'hFFFFFEFD, 32'd553524, -64'sd143362716);
    endtask

    task automatic test_corners;
        op32(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
        op32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        op32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        op32(1'b1, 32'd5, 32'd0, 64'd0);
        op32(1'b0, 32'd5, 32'd0, 64'd0);
        op32(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
        op32(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h7FFFFFFF80000000);
    endtask

    task automatic test_busy_ignore;
        int lat, seen;
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd553524; b32 = 32'd840;
        q32.push_back(64'd464960160);
        @(posedge clk); #1 start32 = 1'b0;
        repeat (4) @(negedge clk);
        start32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
        @(negedge clk);
        start32 = 1'b0;
        for (lat = 5; lat < 40; lat++) begin
            @(negedge clk);
            if (done32 === 1'b1) break;
        end
        tests++;
        if (lat != 18) begin fails++; $display("FAIL busy_ignore_latency got=%0d, expected 18", lat); end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done32 === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL busy_ignore_extra_done got=%0d pulses, expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h12345678;
        q32.push_back(64'(32'hDEADBEEF) * 64'(32'h12345678));
        @(posedge clk); #1 start32 = 1'b0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (done32 === 1'b1) break;
        end
        tests++;
        if (lat != 18) begin fails++; $display("FAIL b2b_first_latency got=%0d, expected 18", lat); end
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'hFFFFFC18; b32 = 32'd999;
        q32.push_back(-64'sd999000);
        @(posedge clk);
        @(posedge clk); #1 start32 = 1'b0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (done32 === 1'b1) break;
        end
        tests++;
        if (lat != 18) begin fails++; $display("FAIL b2b_second_latency got=%0d, expected 18", lat); end
    endtask

    task automatic test_midrun_reset;
        int seen;
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd12345; b32 = 32'd678;
        @(posedge clk); #1 start32 = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy32 !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy busy=%b, expected 0", busy32); end
        tests++;
        if (done32 !== 1'b0) begin fails++; $display("FAIL midrun_reset_done done=%b, expected 0", done32); end
        tests++;
        if (out32 !== 64'd0) begin fails++; $display("FAIL midrun_reset_out out=%h, expected 0", out32); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done32 === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL midrun_reset_no_done got=%0d pulses, expected 0", seen); end
        op32(1'b1, 32'd12345, 32'd678, 64'd8369910);
    endtask

    task automatic test_w8_sweep;
        logic [7:0] pts[6];
        pts = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    op8(s[0], pts[i], pts[j]);
        for (int k = 0; k < 300; k++) op8(1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_w4_exhaustive;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(s[0], x[3:0], y[3:0]);
    endtask

    task automatic test_w64_random;
        op64(1'b1, 64'h8000000000000000, 64'h8000000000000000);
        op64(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        op64(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF);
        for (int k = 0; k < 500; k++) op64(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    initial begin
        test_reset;
        test_signed;
        test_corners;
        test_busy_ignore;
        test_back_to_back;
        test_midrun_reset;
        test_w8_sweep;
        test_w4_exhaustive;
        test_w64_random;
        repeat (4) @(negedge clk);
        tests++;
        if (q32.size() + q8.size() + q4.size() + q64.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain pending=%0d, expected 0", q32.size() + q8.size() + q4.size() + q64.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
